// File: rtl/mips_pkg.sv
// ============================================================================
// Module      : mips_pkg
// Description : Shared widths, constants, opcodes and fetch entry type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;

    localparam logic [INST_W-1:0] NOP = 32'h0000_0000;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000,
        OP_BEQ   = 6'b000100,
        OP_LW    = 6'b100011,
        OP_SW    = 6'b101011
    } opcode_e;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(3);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// Module      : fetch_queue
// Description : Synchronous FIFO of {pc, inst} with push, pop, flush, count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue
    import mips_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  fetch_entry_t                 wdata,
    input  logic                         pop,
    input  logic                         flush,
    output logic                         valid,
    output fetch_entry_t                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t           mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic                   do_push;
    logic                   do_pop;

    // Flush wins over a same-cycle push: that word belongs to the old path.
    assign do_push = push && !flush;
    assign do_pop  = pop && (count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '{pc: '0, inst: NOP};
            end
        end else if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign valid = (count != '0);
    assign head  = mem[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/inst_fetch_unit.sv
// ============================================================================
// Module      : inst_fetch_unit
// Description : PC, instruction memory issue/response tracking and redirect.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int                DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] pc_q;
    logic              inflight_q;
    logic [ADDR_W-1:0] inflight_pc_q;
    logic              squash_q;

    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    occupancy;
    logic              pop;
    logic              accept;
    logic              resp_live;
    logic              inflight_next;
    fetch_entry_t      push_entry;
    fetch_entry_t      head;

    assign pop       = inst_valid && inst_ready;
    assign occupancy = {1'b0, count} + (CNT_W+1)'(inflight_q);

    // Counting the outstanding read as occupied guarantees room for its return.
    assign imem_req  = !rst && !redirect_valid &&
                       ((occupancy < (CNT_W+1)'(DEPTH)) || pop);
    assign imem_addr = pc_q;
    assign accept    = imem_req && imem_ready;

    // Responses with nothing outstanding, or belonging to a squashed path, are dropped.
    assign resp_live     = imem_rvalid && inflight_q && !squash_q;
    assign inflight_next = accept ? 1'b1 : (imem_rvalid ? 1'b0 : inflight_q);
    assign push_entry    = '{pc: inflight_pc_q, inst: imem_rdata};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            squash_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_next;
            if (redirect_valid) begin
                pc_q     <= word_align(redirect_pc);
                squash_q <= inflight_next;
            end else begin
                if (accept) begin
                    pc_q          <= pc_q + ADDR_W'(4);
                    inflight_pc_q <= pc_q;
                end
                if (imem_rvalid && squash_q) begin
                    squash_q <= 1'b0;
                end
            end
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_fetch_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (resp_live),
        .wdata (push_entry),
        .pop   (pop),
        .flush (redirect_valid),
        .valid (inst_valid),
        .head  (head),
        .count (count)
    );

    assign inst    = head.inst;
    assign inst_pc = head.pc;

endmodule

`default_nettype wire

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Instruction fetch stage that sits directly upstream of the processor's decode/execute path. Owns the program counter, issues word reads to the instruction memory, buffers returned instructions in a small prefetch queue, and hands them downstream with their PC over a valid/ready handshake. A branch redirect (BEQ taken, later jumps) flushes the queue and discards any in-flight read.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset.
- `DEPTH`, default 2: prefetch queue entries, power of two, ≥2.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `imem_req` output 1: read request this cycle.
- `imem_addr` output 32: byte address of request, bits [1:0] always 0.
- `imem_ready` input 1: memory accepts request this cycle (accept = `imem_req && imem_ready`).
- `imem_rvalid` input 1: read data valid; asserted exactly 1 cycle after each accept.
- `imem_rdata` input 32: instruction word.
- `inst_valid` output 1: queue head valid.
- `inst_ready` input 1: consumer takes head (pop = `inst_valid && inst_ready`).
- `inst` output 32: head instruction.
- `inst_pc` output 32: address the head was fetched from.
- `redirect_valid` input 1: single-cycle redirect strobe.
- `redirect_pc` input 32: new fetch address; bits [1:0] ignored (forced 0).

## Operation
- State: `pc_q` (next fetch address), `inflight_q` (0/1), `inflight_pc_q`, `squash_q`, queue of {pc, inst}, `count_q`.
- Issue: `imem_req = !redirect_valid && (count_q + inflight_q < DEPTH || pop)`; `imem_addr = pc_q`. On accept: `pc_q <= pc_q + 4` (wraps 32'hFFFF_FFFC -> 0), `inflight_q <= 1`, `inflight_pc_q <= pc_q`.
- Memory may hold `imem_ready` low indefinitely; `imem_addr` stays stable while `imem_req` high and not accepted.
- Response: on `imem_rvalid` with `squash_q == 0`, push {`inflight_pc_q`, `imem_rdata`}; with `squash_q == 1`, discard and clear `squash_q`. `imem_rvalid` with no request outstanding is ignored (checked by assertion).
- Push and pop in the same cycle: both happen, `count_q` unchanged. Occupancy never exceeds `DEPTH` by construction of the issue rule.
- Redirect (priority over everything else this cycle): `pc_q <= {redirect_pc[31:2], 2'b00}`; queue cleared at clock edge; `squash_q <= inflight_q_next` (an outstanding or same-cycle-returning read not yet pushed is discarded); no request issued this cycle. A pop in the redirect cycle completes normally (consumer has taken that instruction).
- Back-to-back redirects: last one wins; each restarts fetch.

## Timing
- Reset values: `imem_req` 0 while `rst` high, `imem_addr` = `RESET_PC`, `inst_valid` 0, `inst` 0, `inst_pc` 0, `count_q` 0, `inflight_q` 0, `squash_q` 0.
- First request in the first cycle after `rst` falls, address `RESET_PC`.
- Latency: accept at cycle N -> `imem_rvalid` N+1 -> `inst_valid` with that word at N+2.
- Throughput: one instruction per cycle sustained when `imem_ready` and `inst_ready` both held high.
- Redirect at cycle R -> request to `redirect_pc` at R+1 (if `imem_ready`) -> `inst_valid` at R+3; `inst_valid` low in R+1 and R+2.
- `rst` asserted mid-operation: all state returns to reset values immediately; a later stray `imem_rvalid` is ignored.
- Outputs `inst`, `inst_pc`, `inst_valid` held stable while `inst_valid && !inst_ready`.

## Structure
- Shared package `mips_pkg`: `INST_W = 32`, `ADDR_W = 32`, `NOP = 32'h0000_0000`, opcode/funct constants (R-type 6'b000000, LW 6'b100011, SW 6'b101011, BEQ 6'b000100) shared with decode and ALU.
- Sub-module `fetch_queue`: synchronous FIFO of {pc, inst} with push, pop, flush, count; async active-high reset. Fetch control (PC, in-flight/squash tracking, issue rule) stays in `inst_fetch_unit`.

## Test plan
- Reset release, memory always ready, returns `imem_rdata = addr + 32'h1000`, consumer always ready -> requests 0,4,8,…; `inst_valid` from cycle 2; `inst_pc` 0,4,8 with `inst` 0x1000,0x1004,0x1008 one per cycle.
- Consumer holds `inst_ready` low 10 cycles -> exactly `DEPTH` (2) instructions buffered, `imem_req` drops, no loss/duplication; after release PCs continue 0,4,8,12 contiguously.
- Redirect to 32'h0000_0040 while a read of 0x8 is in flight -> 0x8 response discarded, queue empty, next request 0x40, next `inst_pc` 0x40.
- Redirect with `redirect_pc = 32'h0000_0053` -> fetch resumes at 0x50.
- `imem_ready` toggling 1-0-0-1 -> `imem_addr` stable while stalled, fetched PC sequence gapless.
- `rst` pulsed with two entries queued and a read in flight -> `inst_valid` 0 immediately, stray `imem_rvalid` ignored, fetch restarts at `RESET_PC`.
